// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay_line block: mode encodings and
// the clamp that turns the requested delay into the effective delay D.
package delay_pkg;

  localparam logic MODE_TRANSPORT = 1'b0;
  localparam logic MODE_INERTIAL  = 1'b1;

  // A request of 0 behaves as 1; requests past the line length saturate.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_d);
    if (req < 1) return 1;
    if (req > max_d) return max_d;
    return req;
  endfunction

endpackage

// File: rtl/inertial_filter_chan.sv
// One channel of the inertial filter: output register, run-length counter and
// the one-cycle "pulse rejected" flag.
module inertial_filter_chan
  import delay_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          mode_i,
  input  logic          din_i,
  input  logic          tap_i,
  input  logic [DW-1:0] d_i,
  output logic          q_o,
  output logic          filtered_o
);

  logic          q_q, q_d;
  logic [DW-1:0] c_q, c_d;
  logic          filt_q, filt_d;
  logic [DW-1:0] d_m1;

  assign d_m1 = d_i - DW'(1);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q_q    <= 1'b0;
      c_q    <= '0;
      filt_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      c_q    <= c_d;
      filt_q <= filt_d;
    end
  end

  // ">=" rather than "==" so a shortened delay releases a run already past it.
  always_comb begin
    q_d    = q_q;
    c_d    = c_q;
    filt_d = 1'b0;
    if (mode_i == MODE_TRANSPORT) begin
      q_d = tap_i;
      c_d = '0;
    end else if (din_i == q_q) begin
      c_d    = '0;
      filt_d = (c_q != '0);
    end else if (c_q >= d_m1) begin
      q_d = din_i;
      c_d = '0;
    end else begin
      c_d = c_q + DW'(1);
    end
  end

  assign q_o        = q_q;
  assign filtered_o = filt_q;

endmodule

// File: rtl/delay_line.sv
// Multi-channel programmable delay line: shared shift register and tap mux,
// with a per-channel inertial filter selectable at runtime.
module delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] filtered
);

  logic [WIDTH-1:0] sreg_q [MAX_DELAY];
  logic [DW-1:0]    d_eff;
  logic [DW-1:0]    d_m1;
  logic [WIDTH-1:0] tap;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] filt_vec;

  assign d_eff = DW'(clamp_delay(32'(delay), MAX_DELAY));
  assign d_m1  = d_eff - DW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MAX_DELAY; k++) sreg_q[k] <= '0;
    end else begin
      sreg_q[0] <= din;
      for (int k = 1; k < MAX_DELAY; k++) sreg_q[k] <= sreg_q[k-1];
    end
  end

  // Compare-based mux keeps the index width independent of MAX_DELAY.
  always_comb begin
    tap = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (d_m1 == DW'(k)) tap = sreg_q[k];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    inertial_filter_chan #(.DW(DW)) u_chan (
      .clock_i    (clock),
      .reset_ni   (reset_n),
      .mode_i     (mode),
      .din_i      (din[i]),
      .tap_i      (tap[i]),
      .d_i        (d_eff),
      .q_o        (q_vec[i]),
      .filtered_o (filt_vec[i])
    );
  end

  assign dout     = (mode == MODE_INERTIAL) ? q_vec : tap;
  assign filtered = filt_vec;

endmodule

// File: tb/tb_delay_line.sv
// Directed, self-checking bench for delay_line (WIDTH=4, MAX_DELAY=16).
module tb_delay_line;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mode;
  logic [4:0] delay;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] filtered;

  int checks = 0;
  int errors = 0;

  delay_line #(.WIDTH(4), .MAX_DELAY(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .mode     (mode),
    .delay    (delay),
    .din      (din),
    .dout     (dout),
    .filtered (filtered)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; delay = 5'd5; din = 4'hF;
    #12 reset_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (dout !== 4'hF) begin
      errors++; $display("FAIL reset_pre_dout got %h exp %h", dout, 4'hF);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (dout !== 4'h0) begin
      errors++; $display("FAIL reset_async_dout got %h exp %h", dout, 4'h0);
    end
    checks++;
    if (filtered !== 4'h0) begin
      errors++; $display("FAIL reset_async_filtered got %h exp %h", filtered, 4'h0);
    end
    din = 4'h0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dout !== 4'h0) begin
        errors++; $display("FAIL reset_post_dout cyc %0d got %h exp %h", i, dout, 4'h0);
      end
    end
    // inertial: build up a pending filter flag, then reset over it
    mode = 1'b1; delay = 5'd2; din = 4'hF;
    tick(); tick();
    checks++;
    if (dout !== 4'hF) begin
      errors++; $display("FAIL reset_inert_rise got %h exp %h", dout, 4'hF);
    end
    din = 4'h0; tick();
    din = 4'hF; tick();
    checks++;
    if (filtered !== 4'hF) begin
      errors++; $display("FAIL reset_inert_filt got %h exp %h", filtered, 4'hF);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (dout !== 4'h0 || filtered !== 4'h0) begin
      errors++; $display("FAIL reset_inert_async got dout %h filt %h exp 0 0", dout, filtered);
    end
    din = 4'h0; mode = 1'b0;
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_transport();
    mode = 1'b0; delay = 5'd5; din = 4'h0;
    repeat (6) tick();
    din = 4'hA;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dout !== ((i >= 4) ? 4'hA : 4'h0)) begin
        errors++; $display("FAIL transport_step cyc %0d got %h exp %h", i, dout, (i >= 4) ? 4'hA : 4'h0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      din = (i < 2) ? 4'hB : 4'hA;
      tick();
      checks++;
      if (dout !== ((i == 4 || i == 5) ? 4'hB : 4'hA)) begin
        errors++; $display("FAIL transport_pulse cyc %0d got %h exp %h", i, dout, (i == 4 || i == 5) ? 4'hB : 4'hA);
      end
    end
  endtask

  task automatic test_inertial();
    mode = 1'b0; delay = 5'd5; din = 4'h0;
    repeat (6) tick();
    mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = (i < 3) ? 4'h2 : 4'h0;
      tick();
      checks++;
      if (dout !== 4'h0) begin
        errors++; $display("FAIL inertial_short_dout cyc %0d got %h exp %h", i, dout, 4'h0);
      end
      checks++;
      if (filtered !== ((i == 3) ? 4'h2 : 4'h0)) begin
        errors++; $display("FAIL inertial_short_filt cyc %0d got %h exp %h", i, filtered, (i == 3) ? 4'h2 : 4'h0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      din = (i < 7) ? 4'h2 : 4'h0;
      tick();
      checks++;
      if (dout !== ((i >= 4 && i <= 10) ? 4'h2 : 4'h0)) begin
        errors++; $display("FAIL inertial_long_dout cyc %0d got %h exp %h", i, dout, (i >= 4 && i <= 10) ? 4'h2 : 4'h0);
      end
      checks++;
      if (filtered !== 4'h0) begin
        errors++; $display("FAIL inertial_long_filt cyc %0d got %h exp %h", i, filtered, 4'h0);
      end
    end
  endtask

  task automatic test_clamp();
    mode = 1'b0; delay = 5'd0; din = 4'h0;
    repeat (2) tick();
    din = 4'h5; tick();
    checks++;
    if (dout !== 4'h5) begin
      errors++; $display("FAIL clamp_zero got %h exp %h", dout, 4'h5);
    end
    delay = 5'd1; din = 4'hA; tick();
    checks++;
    if (dout !== 4'hA) begin
      errors++; $display("FAIL clamp_one got %h exp %h", dout, 4'hA);
    end
    delay = 5'd20; din = 4'h0;
    repeat (17) tick();
    din = 4'hF;
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++;
      if (dout !== ((i >= 15) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL clamp_max cyc %0d got %h exp %h", i, dout, (i >= 15) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; delay = 5'd5; din = 4'h5;
    repeat (8) tick();
    for (int i = 0; i < 12; i++) begin
      mode = (i >= 3 && i < 7);
      tick();
      checks++;
      if (dout !== 4'h5) begin
        errors++; $display("FAIL mode_switch_dout cyc %0d got %h exp %h", i, dout, 4'h5);
      end
      checks++;
      if (filtered !== 4'h0) begin
        errors++; $display("FAIL mode_switch_filt cyc %0d got %h exp %h", i, filtered, 4'h0);
      end
    end
  endtask

  task automatic test_simultaneous();
    mode = 1'b0; delay = 5'd4; din = 4'h0;
    repeat (6) tick();
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = (i < 3) ? 4'h4 : 4'h0;
      tick();
      checks++;
      if (dout !== 4'h0) begin
        errors++; $display("FAIL simul_dout cyc %0d got %h exp %h", i, dout, 4'h0);
      end
      checks++;
      if (filtered !== ((i == 3) ? 4'h4 : 4'h0)) begin
        errors++; $display("FAIL simul_filt cyc %0d got %h exp %h", i, filtered, (i == 3) ? 4'h4 : 4'h0);
      end
    end
    for (int i = 0; i < 12; i++) begin
      din = (i < 4) ? 4'h4 : 4'h0;
      tick();
      checks++;
      if (dout !== ((i >= 3 && i <= 6) ? 4'h4 : 4'h0)) begin
        errors++; $display("FAIL simul_pass cyc %0d got %h exp %h", i, dout, (i >= 3 && i <= 6) ? 4'h4 : 4'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transport();
    test_inertial();
    test_clamp();
    test_mode_switch();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_line.md
# delay_line

Parametrised multi-channel digital delay line for the delay examples: each of `WIDTH` single-bit channels is delayed by a runtime-programmable number of clock cycles. It has two modes. In transport mode every pulse passes through unchanged. In inertial mode pulses shorter than the programmed delay are rejected. It is the clocked, configurable successor to the fixed gate-delay examples and sits between stimulus sources and the logic under observation, as a reusable delay/glitch-filter stage.

## Interface
- `WIDTH`, 4: number of independent channels.
- `MAX_DELAY`, 16: largest supported delay in cycles. Must be ≥ 2.
- `DW`, `$clog2(MAX_DELAY+1)`: width of the `delay` port. Derived; do not override.

- `clock`: input, 1 bit. Single clock, rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `mode`: input, 1 bit. 0 = transport, 1 = inertial. Sampled every edge.
- `delay`: input, `DW` bits. Requested delay in cycles. Sampled every edge.
- `din`: input, `WIDTH` bits. Channel inputs, sampled on the rising edge.
- `dout`: output, `WIDTH` bits. Delayed or filtered outputs.
- `filtered`: output, `WIDTH` bits. One-cycle pulse per channel when inertial mode rejects a pulse.

## Operation
- Effective delay D = clamp(`delay`, 1, `MAX_DELAY`). A value of 0 acts as 1; values above `MAX_DELAY` act as `MAX_DELAY`.
- **Shift register:** `MAX_DELAY` stages per channel, s[0..MAX_DELAY-1]. Every edge, s[0] ← `din` and s[k] ← s[k-1]. It runs in both modes.
- **Transport mode:** `dout` = s[D-1]. Any pulse of width W cycles reappears W cycles wide, D edges later.
- **Inertial mode:** each channel has an output register q[i] and a counter c[i] of `DW` bits. On each edge:
  - If `din[i]` == q[i]: c ← 0. If c was nonzero, `filtered[i]` ← 1 for the next cycle.
  - Else if c == D-1: q ← `din[i]` and c ← 0.
  - Else: c ← c+1.
  - `dout[i]` = q[i].
- A transition held for D consecutive sampled edges propagates on the D-th edge, the same latency as transport mode. A shorter excursion is dropped and flagged on `filtered`.
- **While in transport mode:** q[i] ← s[D-1][i] every edge, c ← 0, and `filtered` is held 0. A switch to inertial mode is therefore seamless.
- **Inertial → transport switch:** `dout` immediately shows s[D-1]. A step in `dout` is permitted.
- **Delay change in transport mode:** the tap moves immediately. `dout` may skip or repeat samples.
- **Delay change in inertial mode:** takes effect on the next comparison. If c ≥ new D-1 and input ≠ q, then q updates on that edge.
- **Channel independence:** channels share `mode` and `delay` only.

## Timing
- Reset (`reset_n` low, asynchronous, any time): all s, q and c clear to 0. `dout` = 0 and `filtered` = 0 immediately, and they stay 0 until the first edge after release.
- The first edge after release is a normal cycle.
- **Latency:** `din` sampled at edge n appears on `dout` after edge n+D-1 settles, i.e. D edges counting the sampling edge.
- **Transport `dout`:** combinational from registers and the `delay` port through a `MAX_DELAY`:1 mux.
- **Inertial `dout` and `filtered`:** directly registered.
- **Simultaneous events:** if input returns to q on the same edge that c would reach D-1, the equality branch wins, so the pulse is filtered.
- Reset assertion mid-pulse discards all pending state. No pulse completes after reset.

## Structure
- **Shared package `delay_pkg`:** constants `MODE_TRANSPORT` = 1'b0 and `MODE_INERTIAL` = 1'b1, plus the clamp function for D.
- **Sub-module `inertial_filter_chan`:** holds one channel's q and c, the compare/count logic and the `filtered` flop. Inputs are the tap value, D and mode. It is generate-instantiated `WIDTH` times.
- The shared shift register and tap mux live in the top.

## Test plan
- **Reset:** hold `din`=4'hF for 20 cycles, then pull `reset_n` low between edges → `dout`=0 and `filtered`=0 at once. After release with `din`=0, `dout` stays 0.
- **Transport, delay=5:** `din` 0→4'hA at edge 10 → `dout`=4'hA from edge 14 onward. A 2-cycle pulse on ch0 → a 2-cycle pulse on `dout[0]` 5 edges later.
- **Inertial, delay=5:** a 3-cycle high pulse on ch1 → `dout[1]` stays 0 and `filtered[1]`=1 for exactly one cycle after the pulse ends. A 7-cycle pulse → `dout[1]` high for 7 cycles with a 5-edge delay.
- **Clamping:** `delay`=0 behaves identically to `delay`=1 (1-edge latency). `delay`=20 behaves as 16.
- **Mode switch:** steady `din`=4'h5 with the mode toggled transport → inertial → transport → `dout` remains 4'h5 with no glitch and `filtered` remains 0.
- **Simultaneous event, delay=4, inertial:** a 3-cycle pulse, so the input returns to q on the edge c would reach 3 → filtered, and `dout` unchanged.
